// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, bit-period helper and frame lengths.
// Used by uart_tx and by the receiver-side bench.
package uart_pkg;

   typedef logic [2:0] uart_state_t;

   localparam uart_state_t ST_IDLE   = 3'd0;
   localparam uart_state_t ST_START  = 3'd1;
   localparam uart_state_t ST_DATA   = 3'd2;
   localparam uart_state_t ST_PARITY = 3'd3;
   localparam uart_state_t ST_STOP   = 3'd4;

   localparam int DATA_BITS         = 8;
   localparam int FRAME_BITS_8N1    = 10;
   localparam int FRAME_BITS_PARITY = 11;

   function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, pulses bit_done on the last count.
// Cleared on a new frame or abort so every bit starts on a fresh period.
module uart_tx_baud #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic bit_done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         if (count == LAST) begin
            count <= '0;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

   assign bit_done = enable && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, LSB-first 8N1 (8E1/8O1 when UART_TX_PARITY_EN is defined); one byte per valid/ready
// handshake, tx falls the edge after the handshake; ready is low for the whole frame (no queueing).
module uart_tx
   import uart_pkg::*;
#(
   parameter int BAUD_RATE  = 9600,
   parameter int CLOCK_FREQ = 38400000,
   parameter int PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       soft_reset,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);

   if (CLKS_PER_BIT < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
      $error("uart_tx: CLOCK_FREQ/BAUD_RATE must be >= 2 and PARITY_ODD must be 0 or 1");
   end

   uart_state_t state, state_nxt;
   logic [7:0]  shift, shift_nxt;
   logic [2:0]  bit_idx, bit_idx_nxt;
   logic        tx_nxt;
   logic        take;
   logic        bit_done;
`ifdef UART_TX_PARITY_EN
   logic        parity_bit, parity_nxt;
`endif

   // ready mirrors (state == ST_IDLE) but comes from a flop, so take has no path from state decode
   assign take = valid && ready;
   assign busy = ~ready;

   uart_tx_baud #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst     (rst),
      .clear   (take || soft_reset),
      .enable  (state != ST_IDLE),
      .bit_done(bit_done)
   );

   always_comb begin
      state_nxt   = state;
      shift_nxt   = shift;
      bit_idx_nxt = bit_idx;
`ifdef UART_TX_PARITY_EN
      parity_nxt  = parity_bit;
`endif
      case (state)
         ST_IDLE: begin
            if (take) begin
               state_nxt   = ST_START;
               shift_nxt   = data;
               bit_idx_nxt = 3'd0;
`ifdef UART_TX_PARITY_EN
               parity_nxt  = (^data) ^ 1'(PARITY_ODD);
`endif
            end
         end
         ST_START: begin
            if (bit_done) begin
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_done) begin
               shift_nxt = {1'b0, shift[7:1]};
               if (bit_idx == 3'(DATA_BITS - 1)) begin
                  bit_idx_nxt = 3'd0;
`ifdef UART_TX_PARITY_EN
                  state_nxt   = ST_PARITY;
`else
                  state_nxt   = ST_STOP;
`endif
               end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_done) begin
               state_nxt = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (bit_done) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt   = ST_IDLE;
            shift_nxt   = 8'h00;
            bit_idx_nxt = 3'd0;
         end
      endcase

      if (soft_reset) begin
         state_nxt   = ST_IDLE;
         shift_nxt   = 8'h00;
         bit_idx_nxt = 3'd0;
      end
   end

   // Line level is decoded from the next state so tx changes on the same edge as the state.
   always_comb begin
      tx_nxt = 1'b1;
      case (state_nxt)
         ST_START:  tx_nxt = 1'b0;
         ST_DATA:   tx_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_nxt = parity_nxt;
`endif
         default:   tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         shift   <= 8'h00;
         bit_idx <= 3'd0;
         tx      <= 1'b1;
         ready   <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         shift   <= shift_nxt;
         bit_idx <= bit_idx_nxt;
         tx      <= tx_nxt;
         ready   <= (state_nxt == ST_IDLE);
`ifdef UART_TX_PARITY_EN
         parity_bit <= parity_nxt;
`endif
      end
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter, 8N1 framing (optional parity), the transmit-side counterpart of the UART receiver. Accepts one byte per valid/ready handshake from the host-side logic, serialises it LSB-first on `tx` at `BAUD_RATE` derived from `CLOCK_FREQ`, and holds the line idle-high between frames. It sits between the command/response logic and the external serial pin.

## Interface
- `BAUD_RATE`, 9600: serial bit rate, bits/s.
- `CLOCK_FREQ`, 38400000: `clk` frequency, Hz.
- `PARITY_ODD`, 0: parity sense, only used when parity is compiled in. 0 = even, 1 = odd.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `soft_reset`  in  1  synchronous abort; returns to IDLE and drives line high.
- `data`  in  8  byte to transmit; sampled on the handshake cycle only.
- `valid`  in  1  `data` is offered.
- `ready`  out  1  transmitter can accept a byte (high only in IDLE).
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  frame in progress (`!ready`).

## Operation
- CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer truncation). It must be ≥ 2; an elaboration-time check enforces this. The bit counter is $clog2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1.
- States and transitions:
  - IDLE → START on `valid && ready`. The byte is latched into the shift register at that edge.
  - START: `tx`=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: bit index 0..7, `tx`=shift[0], shifting right every CLKS_PER_BIT cycles. After bit 7 → PARITY if compiled in, else STOP.
  - PARITY: `tx`=^byte XOR PARITY_ODD for CLKS_PER_BIT cycles → STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles → IDLE.
- `ready`=1 only in IDLE. `valid` without `ready` is ignored. `data` changes during a frame have no effect.
- `soft_reset` takes priority over every state transition and over the handshake. The next edge gives IDLE, `tx`=1, counters cleared. A truncated frame on the line is acceptable.
- Illegal state encoding → IDLE.
- Reset values: `tx`=1, `ready`=1, `busy`=0, state IDLE, counters 0, shift register 0.
- `rst` asserted mid-frame: outputs return to their reset values immediately (asynchronous).

## Timing
- Handshake at edge N: `tx` falls at edge N+1 and `ready` is low from N+1.
- Each bit lasts exactly CLKS_PER_BIT clocks. The frame is 10·CLKS_PER_BIT clocks (11· with parity), counted from the `tx` fall to the end of the stop bit.
- `ready` rises on the edge that ends the stop bit. The next handshake can occur in that cycle, which gives one idle-high clock minimum between frames.
- `tx` is registered: no combinational path from any input to `tx` or `ready`.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is present and the frame is 11 bits, with parity per `PARITY_ODD`.
- Not defined: the PARITY state and its logic are absent, `PARITY_ODD` is ignored, and the frame is 10 bits (8N1).

## Structure
- Shared package `uart_pkg`:
  - state encoding typedef (IDLE, START, DATA, PARITY, STOP)
  - `clks_per_bit(clock_freq, baud_rate)` constant function
  - frame-length constants, used by both uart_tx and the receiver bench.
- One sub-module, `uart_tx_baud`: a bit-period counter.
  - Cleared on handshake or `soft_reset`.
  - Produces a one-cycle `bit_done` pulse at count CLKS_PER_BIT-1.
- The FSM, shift register and bit index stay in `uart_tx`.

## Test plan
All scenarios use CLOCK_FREQ=1600000, BAUD_RATE=100000, so CLKS_PER_BIT=16.
- Single byte 0xA5 → after the handshake, `tx` sequence (16 clks each) 0,1,0,1,0,0,1,0,1,1. `ready` is low for 160 clks.
- Two bytes 0x00 then 0xFF with `valid` held high → the second start bit begins exactly 1 clk after the first stop bit ends. Bit durations are checked against a receiver model.
- `valid` pulsed mid-frame with 0x3C → ignored. The frame in flight is unchanged and no extra frame is sent.
- `soft_reset` during DATA bit 3 → `tx`=1 and `ready`=1 on the next edge. A following 0x55 transmits correctly.
- `rst` asserted mid-STOP → `tx`=1, `ready`=1, `busy`=0 immediately. After release, 0x81 transmits correctly.
- Parity, `UART_TX_PARITY_EN` defined, PARITY_ODD=0:
  - 0xA5 → parity bit 0, 176-clk frame.
  - 0x07 → parity bit 1.
